// File: rtl/adler_frame_feeder_if.sv
// adler_frame_feeder_if: host, engine and status signals of the Adler-32 frame feeder.
// Ports:
//   host   in_valid, in_ready, in_data[7:0], in_last
//   engine size_valid, size[31:0], data_start, data[7:0], data_active, checksum[31:0], checksum_valid
//   status result[31:0], result_valid, overflow, timeout, busy
// The slave modport is the feeder; the master modport is the host/engine side.
interface adler_frame_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        size_valid;
    logic [31:0] size;
    logic        data_start;
    logic [7:0]  data;
    logic        data_active;
    logic [31:0] checksum;
    logic        checksum_valid;
    logic [31:0] result;
    logic        result_valid;
    logic        overflow;
    logic        timeout;
    logic        busy;
    modport slave (
        input  in_valid, in_data, in_last, checksum, checksum_valid,
        output in_ready, size_valid, size, data_start, data, data_active,
               result, result_valid, overflow, timeout, busy
    );
    modport master (
        output in_valid, in_data, in_last, checksum, checksum_valid,
        input  in_ready, size_valid, size, data_start, data, data_active,
               result, result_valid, overflow, timeout, busy
    );
endinterface

// File: rtl/adler_frame_feeder.sv
// adler_frame_feeder: buffers one host frame, streams it to the Adler-32 engine and returns its checksum.
// Ports:
//   clock  rising-edge system clock
//   rst    asynchronous active-high reset
//   bus    adler_frame_feeder_if.slave: host byte handshake, engine size/start/data stream,
//          engine checksum capture, result strobe and overflow/timeout/busy status
module adler_frame_feeder #(
    parameter int DEPTH   = 256,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 1024
) (
    input logic clock,
    input logic rst,
    adler_frame_feeder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [2:0] FILL = 3'd0, SIZE = 3'd1, START = 3'd2, STREAM = 3'd3, WAIT = 3'd4;
    localparam logic [AW:0] FULL_M1 = (AW+1)'(DEPTH - 1);
    logic [2:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d, sent_q, sent_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          drop_q, drop_d, overflow_q, overflow_d, timeout_q, timeout_d;
    logic          size_valid_q, size_valid_d, data_start_q, data_start_d;
    logic          data_active_q, data_active_d, result_valid_q, result_valid_d;
    logic [31:0]   size_q, size_d, result_q, result_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    mem [DEPTH];
    logic          in_ready, accept, wr_en;

    // Ready is masked by reset so that every output reads 0 while reset is held.
    assign in_ready = !rst && state_q == FILL && (drop_q || !count_q[AW]);
    assign accept   = bus.in_valid && in_ready;
    // Bytes past a truncated frame are consumed but never stored.
    assign wr_en    = accept && !drop_q;

    always_ff @(posedge clock) if (wr_en) mem[wr_ptr_q] <= bus.in_data;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        sent_d         = sent_q;
        timer_d        = timer_q;
        drop_d         = drop_q;
        overflow_d     = overflow_q;
        timeout_d      = timeout_q;
        size_d         = size_q;
        result_d       = result_q;
        size_valid_d   = 1'b0;
        data_start_d   = 1'b0;
        data_active_d  = 1'b0;
        result_valid_d = 1'b0;
        data_d         = 8'h00;
        case (state_q)
            FILL: if (accept) begin
                if (drop_q) drop_d = !bus.in_last;
                else begin
                    // The first stored byte of a frame retires the previous frame's status.
                    if (count_q == '0) begin
                        overflow_d = 1'b0;
                        timeout_d  = 1'b0;
                    end
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + (AW+1)'(1);
                    if (bus.in_last || count_q == FULL_M1) begin
                        state_d      = SIZE;
                        size_valid_d = 1'b1;
                        size_d       = 32'(count_q) + 32'd1;
                        overflow_d   = overflow_d || !bus.in_last;
                        drop_d       = !bus.in_last;
                    end
                end
            end
            SIZE: begin
                state_d      = START;
                data_start_d = 1'b1;
            end
            START, STREAM: begin
                // sent_q counts bytes already on the data output; it restarts at START.
                if (state_q == STREAM && sent_q == count_q) begin
                    state_d = WAIT;
                    timer_d = '0;
                end else begin
                    state_d       = STREAM;
                    data_d        = mem[rd_ptr_q];
                    data_active_d = 1'b1;
                    rd_ptr_d      = rd_ptr_q + AW'(1);
                    sent_d        = state_q == START ? (AW+1)'(1) : sent_q + (AW+1)'(1);
                end
            end
            WAIT: begin
                if (bus.checksum_valid || timer_q == TW'(TIMEOUT - 1)) begin
                    state_d        = FILL;
                    count_d        = '0;
                    sent_d         = '0;
                    wr_ptr_d       = '0;
                    rd_ptr_d       = '0;
                    result_d       = bus.checksum_valid ? bus.checksum : result_q;
                    result_valid_d = bus.checksum_valid;
                    timeout_d      = !bus.checksum_valid;
                end else timer_d = timer_q + TW'(1);
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q        <= FILL;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            sent_q         <= '0;
            timer_q        <= '0;
            drop_q         <= 1'b0;
            overflow_q     <= 1'b0;
            timeout_q      <= 1'b0;
            size_valid_q   <= 1'b0;
            data_start_q   <= 1'b0;
            data_active_q  <= 1'b0;
            result_valid_q <= 1'b0;
            size_q         <= '0;
            result_q       <= '0;
            data_q         <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            sent_q         <= sent_d;
            timer_q        <= timer_d;
            drop_q         <= drop_d;
            overflow_q     <= overflow_d;
            timeout_q      <= timeout_d;
            size_valid_q   <= size_valid_d;
            data_start_q   <= data_start_d;
            data_active_q  <= data_active_d;
            result_valid_q <= result_valid_d;
            size_q         <= size_d;
            result_q       <= result_d;
            data_q         <= data_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.size_valid   = size_valid_q;
    assign bus.size         = size_q;
    assign bus.data_start   = data_start_q;
    assign bus.data         = data_q;
    assign bus.data_active  = data_active_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.timeout      = timeout_q;
    assign bus.busy         = state_q != FILL;
endmodule

// File: tb/tb_adler_frame_feeder.sv
// tb_adler_frame_feeder: randomized frames checked every cycle against a schedule-based frame model.
module tb_adler_frame_feeder;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic clock = 0;
    logic rst = 0;
    always #5 clock = ~clock;

    adler_frame_feeder_if bus();
    adler_frame_feeder #(.DEPTH(DEPTH), .AW(3), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0, n_err = 0, cyc = 0;
    // Model: a frame launched at cycle s_c shows size_valid at s_c, data_start at s_c+1,
    // byte i at s_c+2+i, then waits from s_c+2+n_len until end_c.
    bit have, drop, ovf, tmo, got, started, last_acc, use_cs, spur_en;
    bit eng_on = 1;
    int s_c, n_len, end_c, resp_c, force_dly = -1, rv_cyc = -1;
    logic [31:0] exp_result = 0, force_cs = 0;
    logic [7:0] fr [DEPTH];
    logic [7:0] cur [$];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        have = 0; drop = 0; ovf = 0; tmo = 0; got = 0;
        cur.delete();
        exp_result = 0; rv_cyc = -1;
    endfunction

    function automatic void model_accept(logic [7:0] b, logic l);
        if (drop) begin
            drop = !l;
            return;
        end
        if (cur.size() == 0) begin ovf = 0; tmo = 0; end
        cur.push_back(b);
        if (l || cur.size() == DEPTH) begin
            if (!l) begin ovf = 1; drop = 1; end
            have = 1; got = 0; s_c = cyc; n_len = cur.size();
            foreach (cur[i]) fr[i] = cur[i];
            cur.delete();
            end_c = s_c + 2 + n_len + TIMEOUT;
            resp_c = eng_on ? s_c + 2 + n_len + (force_dly >= 0 ? force_dly : int'($urandom_range(0, 5))) : -1;
        end
    endfunction

    task automatic tick();
        bit acc, cv_ok, in_wait;
        in_wait = have && cyc >= s_c + 2 + n_len && cyc < end_c;
        bus.checksum_valid = 0;
        if (in_wait && cyc == resp_c) begin
            bus.checksum_valid = 1;
            bus.checksum = use_cs ? force_cs : $urandom;
        end else if (!in_wait && spur_en && $urandom_range(0, 5) == 0) begin
            bus.checksum_valid = 1;
            bus.checksum = $urandom;
        end
        acc = bus.in_valid && !rst && !have;
        cv_ok = bus.checksum_valid && in_wait;
        @(posedge clock);
        cyc++;
        if (cv_ok) begin exp_result = bus.checksum; rv_cyc = cyc; end_c = cyc; got = 1; end
        if (acc) model_accept(bus.in_data, bus.in_last);
        if (have && cyc == end_c) begin tmo |= !got; have = 0; end
        last_acc = acc;
        #1;
    endtask

    task automatic send_byte(logic [7:0] b, logic l);
        int w = 0;
        bus.in_valid = 1; bus.in_data = b; bus.in_last = l;
        do begin tick(); w++; end while (!last_acc && w < 500);
        chk("byte_accepted", last_acc, 1);
        bus.in_valid = 0; bus.in_data = $urandom; bus.in_last = $urandom;
    endtask

    task automatic send_frame(int len);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte($urandom, i == len - 1);
        end
    endtask

    task automatic wait_idle();
        int i = 0;
        while (bus.busy && i < DEPTH + TIMEOUT + 20) begin tick(); i++; end
        chk("idle_reached", bus.busy, 0);
    endtask

    task automatic reset_checks(string t);
        chk({t, "_flags"}, {bus.size_valid, bus.data_start, bus.data_active, bus.result_valid,
                            bus.overflow, bus.timeout, bus.busy, bus.in_ready}, 0);
        chk({t, "_size"}, bus.size, 0);
        chk({t, "_data"}, bus.data, 0);
        chk({t, "_result"}, bus.result, 0);
    endtask

    always @(negedge clock) begin
        int k;
        logic da;
        if (started && !rst) begin
            k = cyc - s_c - 2;
            da = have && k >= 0 && k < n_len;
            chk("size_valid", bus.size_valid, have && cyc == s_c);
            if (have && cyc == s_c) chk("size", bus.size, n_len);
            chk("data_start", bus.data_start, have && cyc == s_c + 1);
            chk("data_active", bus.data_active, da);
            chk("data", bus.data, da ? fr[k] : 8'h00);
            chk("busy", bus.busy, have);
            chk("in_ready", bus.in_ready, !have);
            chk("result_valid", bus.result_valid, cyc == rv_cyc);
            chk("result", bus.result, exp_result);
            chk("overflow", bus.overflow, ovf);
            chk("timeout", bus.timeout, tmo);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active, required finished");
        $fatal(1);
    end

    initial begin
        logic [63:0] v;
        int i;
        bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0;
        bus.checksum = 0; bus.checksum_valid = 0;
        model_reset();
        #1 rst = 1;
        #1 reset_checks("reset_init");
        repeat (2) tick();
        rst = 0;
        started = 1;

        // 'abcde' with the engine answering 0x05C801F0
        use_cs = 1; force_cs = 32'h05C801F0; force_dly = 2;
        for (int j = 0; j < 5; j++) send_byte(8'h61 + 8'(j), j == 4);
        chk("abcde_size_valid", bus.size_valid, 1);
        chk("abcde_size", bus.size, 5);
        tick();
        chk("abcde_data_start", bus.data_start, 1);
        v = 0;
        repeat (5) begin tick(); v = {v[55:0], bus.data}; end
        chk("abcde_data", v, 64'h6162636465);
        i = 0;
        while (!bus.result_valid && i < 40) begin tick(); i++; end
        chk("abcde_result_valid", bus.result_valid, 1);
        chk("abcde_result", bus.result, 32'h05C801F0);
        tick();
        chk("abcde_rv_single", bus.result_valid, 0);
        use_cs = 0; force_dly = -1;
        wait_idle();

        // single-byte frame
        send_byte(8'hFF, 1);
        chk("one_size", bus.size, 1);
        tick(); tick();
        chk("one_data", {bus.data_active, bus.data}, 9'h1FF);
        tick();
        chk("one_wait", {bus.data_active, bus.busy}, 2'b01);
        wait_idle();

        // truncation at DEPTH, then dropped tail, then a clean 2-byte frame
        for (int j = 0; j < DEPTH; j++) send_byte(8'h10 + 8'(j), 0);
        chk("ovf_size", bus.size, DEPTH);
        chk("ovf_flag", bus.overflow, 1);
        send_byte(8'h18, 0);
        send_byte(8'h19, 1);
        chk("ovf_sticky", bus.overflow, 1);
        send_byte(8'hA0, 0);
        chk("ovf_cleared", bus.overflow, 0);
        send_byte(8'hA1, 1);
        chk("ovf_next_size", bus.size, 2);
        wait_idle();

        // no checksum: timeout
        eng_on = 0;
        send_frame(3);
        wait_idle();
        chk("to_flag", bus.timeout, 1);
        chk("to_ready", bus.in_ready, 1);
        eng_on = 1;

        // checksum in the very last WAIT cycle still wins
        force_dly = TIMEOUT - 1;
        send_frame(2);
        wait_idle();
        chk("late_no_timeout", bus.timeout, 0);
        force_dly = -1;

        // reset in the middle of streaming
        send_frame(5);
        tick(); tick(); tick();
        rst = 1;
        #1 reset_checks("reset_mid");
        model_reset();
        repeat (2) tick();
        rst = 0;
        send_frame(3);
        chk("post_rst_size", bus.size, 3);
        wait_idle();

        // randomized frames, spurious checksum strobes, lengths past DEPTH
        spur_en = 1;
        repeat (40) begin
            eng_on = $urandom_range(0, 5) != 0;
            force_dly = $urandom_range(0, 7) == 0 ? TIMEOUT - 1 : -1;
            send_frame($urandom_range(1, DEPTH + 3));
        end
        wait_idle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
